mac_seq_ctrl: RTL and testbench

Sequencer for a single multiply-accumulate datapath. It accepts a start command with a vector length and streams that many data/weight pairs through a valid/ready input handshake. Each accepted pair is accumulated into a SUM_WIDTH register, and the final dot product is presented on a valid/ready output handshake. It sits between the activation/weight feeders and the partial-sum collector, and is the unit the array-level controller instantiates once per processing lane.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_step.sv | 32 +++
 rtl/mac_seq_ctrl.sv | 91 +++++++++
 tb/tb_mac_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC sequencer and its arithmetic step.
package mac_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int SUM_WIDTH  = 16;
  localparam int LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mac_step.sv
// One multiply-accumulate step: unsigned activation times signed weight, added
// modulo 2^SUM_WIDTH, with a signed-overflow indication for that addition.
module mac_step #(
  parameter int DATA_WIDTH = 4,
  parameter int SUM_WIDTH  = 16
) (
  input  logic [SUM_WIDTH-1:0]  acc_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [SUM_WIDTH-1:0]  acc_out,
  output logic                  ovf_step
);

  localparam int PW = 2 * DATA_WIDTH + 2;

  logic signed [DATA_WIDTH:0] d_ext;
  logic signed [DATA_WIDTH:0] w_ext;
  logic signed [PW-1:0]       prod;
  logic signed [SUM_WIDTH-1:0] prod_ext;

  // One extra bit on each operand lets a single signed multiply cover
  // the unsigned-by-signed case without a special path.
  assign d_ext    = {1'b0, data_in};
  assign w_ext    = {weight_in[DATA_WIDTH-1], weight_in};
  assign prod     = PW'(d_ext) * PW'(w_ext);
  assign prod_ext = SUM_WIDTH'(prod);
  assign acc_out  = acc_in + prod_ext;

  assign ovf_step = (acc_in[SUM_WIDTH-1] == prod_ext[SUM_WIDTH-1]) &&
                    (acc_out[SUM_WIDTH-1] != acc_in[SUM_WIDTH-1]);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Per-lane dot-product sequencer: takes a length command, accumulates that many
// data/weight pairs, and hands the result to the partial-sum collector.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH,
  parameter int SUM_WIDTH  = mac_pkg::SUM_WIDTH,
  parameter int LEN_WIDTH  = mac_pkg::LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SUM_WIDTH-1:0]  acc_out,
  output logic                  ovf,
  output logic                  busy
);

  import mac_pkg::*;

  state_t               state;
  logic [SUM_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 ovf_q;
  logic [SUM_WIDTH-1:0] acc_next;
  logic                 ovf_step;

  mac_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_step (
    .acc_in   (acc),
    .data_in  (data_in),
    .weight_in(weight_in),
    .acc_out  (acc_next),
    .ovf_step (ovf_step)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            if (len != '0) begin
              len_q <= len;
              state <= ACC;
            end else begin
              state <= DONE;
            end
          end
        end
        ACC: begin
          // in_ready is high for the whole of ACC, so in_valid alone marks a beat.
          if (in_valid) begin
            acc   <= acc_next;
            ovf_q <= ovf_q | ovf_step;
            cnt   <= cnt + LEN_WIDTH'(1);
            if (cnt == len_q - LEN_WIDTH'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACC) || (state == DONE);
  assign acc_out   = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a per-cycle vector table plus hand-written
// sequences for reset abort and accumulator wrap at an 8-bit sum width.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start8;
  logic [7:0]  len;
  logic        in_valid;
  logic [3:0]  data_in, weight_in;
  logic        out_ready;

  logic        in_ready, out_valid, ovf, busy;
  logic [15:0] acc_out;
  logic        in_ready8, out_valid8, ovf8, busy8;
  logic [7:0]  acc_out8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .weight_in(weight_in), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf), .busy(busy)
  );

  mac_seq_ctrl #(.SUM_WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .len(len),
    .in_valid(in_valid), .in_ready(in_ready8), .data_in(data_in),
    .weight_in(weight_in), .out_valid(out_valid8), .out_ready(out_ready),
    .acc_out(acc_out8), .ovf(ovf8), .busy(busy8)
  );

  typedef struct {
    logic        st;
    logic [7:0]  ln;
    logic        iv;
    logic [3:0]  d;
    logic [3:0]  w;
    logic        ordy;
    logic        e_ird;
    logic        e_ov;
    logic [15:0] e_acc;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t vec(input int st, input int ln, input int iv, input int d,
                               input int w, input int ordy, input int ird, input int ov,
                               input int acc, input int ovf_e, input int bsy);
    vec_t v;
    v.st = st[0];   v.ln = ln[7:0]; v.iv = iv[0]; v.d = d[3:0]; v.w = w[3:0];
    v.ordy = ordy[0]; v.e_ird = ird[0]; v.e_ov = ov[0]; v.e_acc = acc[15:0];
    v.e_ovf = ovf_e[0]; v.e_busy = bsy[0];
    return v;
  endfunction

  task automatic idle_inputs();
    start = 0; start8 = 0; len = 0; in_valid = 0;
    data_in = 0; weight_in = 0; out_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // st ln iv d w ordy | ird ov acc ovf busy  (outputs after the edge)
    // Saturation product: three beats of 15 * -8.
    tbl.push_back(vec(1, 3, 0,  0,  0, 0, 1, 0,    0, 0, 1));
    tbl.push_back(vec(0, 0, 1, 15, -8, 0, 1, 0, -120, 0, 1));
    tbl.push_back(vec(0, 0, 1, 15, -8, 0, 1, 0, -240, 0, 1));
    tbl.push_back(vec(0, 0, 1, 15, -8, 0, 0, 1, -360, 0, 1));
    tbl.push_back(vec(0, 0, 1, 15, -8, 0, 0, 1, -360, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 1, 0, 0, -360, 0, 0));
    // Empty job.
    tbl.push_back(vec(1, 0, 0,  0,  0, 0, 0, 1,    0, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 1, 0, 0,    0, 0, 0));
    // Back-to-back: A=(5,3), start dropped on the DONE handshake, B=(2,-4).
    tbl.push_back(vec(1, 1, 0,  0,  0, 0, 1, 0,    0, 0, 1));
    tbl.push_back(vec(0, 0, 1,  5,  3, 0, 0, 1,   15, 0, 1));
    tbl.push_back(vec(1, 1, 0,  0,  0, 1, 0, 0,   15, 0, 0));
    tbl.push_back(vec(1, 1, 0,  0,  0, 0, 1, 0,    0, 0, 1));
    tbl.push_back(vec(0, 0, 1,  2, -4, 0, 0, 1,   -8, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 1, 0, 0,   -8, 0, 0));
    // Gaps and backpressure: 1*1 + 2*-1 + 3*2 + 4*-2 = -3; start in ACC ignored.
    tbl.push_back(vec(1, 4, 0,  0,  0, 0, 1, 0,    0, 0, 1));
    tbl.push_back(vec(0, 0, 1,  1,  1, 0, 1, 0,    1, 0, 1));
    tbl.push_back(vec(1, 2, 0,  7,  7, 0, 1, 0,    1, 0, 1));
    tbl.push_back(vec(0, 0, 0,  7,  7, 0, 1, 0,    1, 0, 1));
    tbl.push_back(vec(0, 0, 1,  2, -1, 0, 1, 0,   -1, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 0, 1, 0,   -1, 0, 1));
    tbl.push_back(vec(1, 1, 0,  0,  0, 0, 1, 0,   -1, 0, 1));
    tbl.push_back(vec(0, 0, 1,  3,  2, 0, 1, 0,    5, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 0, 1, 0,    5, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 0, 1, 0,    5, 0, 1));
    tbl.push_back(vec(0, 0, 1,  4, -2, 0, 0, 1,   -3, 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(vec(1, 3, 1,  5,  5, 0, 0, 1,   -3, 0, 1));
    tbl.push_back(vec(0, 0, 0,  0,  0, 1, 0, 0,   -3, 0, 0));

    idle_inputs();
    reset_n = 0;
    tick(); tick();
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out",   acc_out,   0);
    check("rst_ovf",       ovf,       0);
    check("rst_busy",      busy,      0);
    reset_n = 1;
    tick();

    foreach (tbl[i]) begin
      start = tbl[i].st; len = tbl[i].ln; in_valid = tbl[i].iv;
      data_in = tbl[i].d; weight_in = tbl[i].w; out_ready = tbl[i].ordy;
      tick();
      check($sformatf("v%0d_in_ready", i),  in_ready,  tbl[i].e_ird);
      check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("v%0d_acc_out", i),   acc_out,   tbl[i].e_acc);
      check($sformatf("v%0d_ovf", i),       ovf,       tbl[i].e_ovf);
      check($sformatf("v%0d_busy", i),      busy,      tbl[i].e_busy);
    end
    idle_inputs();
    tick();

    // Reset mid-job aborts after two beats of (3,2).
    start = 1; len = 4; tick();
    start = 0; in_valid = 1; data_in = 3; weight_in = 2; tick(); tick();
    check("mid_acc_partial", acc_out, 12);
    in_valid = 0; reset_n = 0; tick();
    check("mid_rst_in_ready",  in_ready,  0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_acc_out",   acc_out,   0);
    check("mid_rst_ovf",       ovf,       0);
    check("mid_rst_busy",      busy,      0);
    reset_n = 1; start = 1; len = 1; tick();
    start = 0; in_valid = 1; data_in = 3; weight_in = 2; tick();
    in_valid = 0;
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_acc_out",   acc_out,   6);
    out_ready = 1; tick();
    out_ready = 0;
    check("post_rst_busy", busy, 0);

    // 8-bit accumulator: 105 + 105 wraps to 0xD2 with overflow.
    start8 = 1; len = 2; tick();
    start8 = 0; in_valid = 1; data_in = 15; weight_in = 7; tick();
    check("wrap_acc_first", acc_out8, 8'd105);
    check("wrap_ovf_first", ovf8, 0);
    tick();
    in_valid = 0;
    check("wrap_out_valid", out_valid8, 1);
    check("wrap_acc_out",   acc_out8,   8'hD2);
    check("wrap_ovf",       ovf8,       1);
    check("wrap_main_idle", busy,       0);
    tick();
    check("wrap_ovf_held", ovf8, 1);
    out_ready = 1; tick();
    out_ready = 0;
    check("wrap_ovf_idle", ovf8, 1);
    start8 = 1; len = 0; tick();
    start8 = 0;
    check("wrap_ovf_cleared", ovf8, 0);
    check("wrap_empty_acc",   acc_out8, 0);
    out_ready = 1; tick();
    out_ready = 0;
    check("wrap_busy_done", busy8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
